// File: rtl/cfg_bridge_pkg.sv
// Shared types and frame geometry for the serial configuration bridge.
package cfg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_WDATA,
        ST_RDATA,
        ST_COMMIT,
        ST_ABORT
    } state_t;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_W = 16;
    localparam int FRAME_LEN  = 1 + DEF_ADDR_W + DEF_DATA_W;
    localparam int HDR_LEN    = 1 + DEF_ADDR_W;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_len(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    function automatic int hdr_len(input int addr_w);
        return 1 + addr_w;
    endfunction

endpackage

// File: rtl/cfg_serial_bridge_if.sv
// Register-bank write/read port driven by the serial bridge.
interface cfg_serial_bridge_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
);
    logic              cfg_write;
    logic [ADDR_W-1:0] cfg_address;
    logic [DATA_W-1:0] cfg_data_in;
    logic [DATA_W-1:0] cfg_data_out;

    modport master (output cfg_write, cfg_address, cfg_data_in, input cfg_data_out);
    modport slave  (input cfg_write, cfg_address, cfg_data_in, output cfg_data_out);
endinterface

// File: rtl/cfg_serial_bridge_sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: non-blocking assignments let q take the old meta, giving two real stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/cfg_serial_bridge.sv
// SPI mode-0 frame receiver that turns frames into register-bank writes
// and shifts read data back out on sdo.
module cfg_serial_bridge
    import cfg_bridge_pkg::*;
#(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic sdi,
    output logic sdo,
    output logic busy,
    output logic frame_err,
    cfg_serial_bridge_if.master cfg
);
    localparam int FLEN  = frame_len(ADDR_W, DATA_W);
    localparam int HLEN  = hdr_len(ADDR_W);
    localparam int CNT_W = $clog2(FLEN + 1);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FLEN);
    localparam logic [CNT_W-1:0] HDR_CNT   = CNT_W'(HLEN);

    logic sclk_s, cs_n_s, sdi_s;
    logic sclk_d, sclk_q, cs_n_d, cs_n_q, sdi_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    sync2 u_sync_sclk (.clk(clk), .reset(reset), .d(sclk), .q(sclk_s));
    sync2 u_sync_cs_n (.clk(clk), .reset(reset), .d(cs_n), .q(cs_n_s));
    sync2 u_sync_sdi  (.clk(clk), .reset(reset), .d(sdi),  .q(sdi_s));

    // Edge-detect stage; sdi is delayed alongside so it stays aligned with sclk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_d <= 1'b0;
            sclk_q <= 1'b0;
            cs_n_d <= 1'b0;
            cs_n_q <= 1'b0;
            sdi_d  <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            sclk_q <= sclk_d;
            cs_n_d <= cs_n_s;
            cs_n_q <= cs_n_d;
            sdi_d  <= sdi_s;
        end
    end

    assign sclk_rise = sclk_d & ~sclk_q;
    assign sclk_fall = ~sclk_d & sclk_q;
    assign cs_rise   = cs_n_d & ~cs_n_q;
    assign cs_fall   = ~cs_n_d & cs_n_q;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic [HLEN-1:0]   hdr_sr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_sr;

    logic              bit_take;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  cnt_after;
    logic [HLEN-1:0]   hdr_next;
    logic [DATA_W-1:0] wdata_next;

    // NOTE: every always_comb output gets a value on every path, so no latch can form.
    always_comb begin
        bit_take   = sclk_rise && (count < FRAME_CNT);
        count_inc  = count + CNT_W'(1);
        cnt_after  = bit_take ? count_inc : count;
        hdr_next   = {hdr_sr[HLEN-2:0], sdi_d};
        wdata_next = {wdata[DATA_W-2:0], sdi_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            count           <= '0;
            hdr_sr          <= '0;
            wdata           <= '0;
            rd_sr           <= '0;
            sdo             <= 1'b0;
            busy            <= 1'b0;
            frame_err       <= 1'b0;
            cfg.cfg_write   <= 1'b0;
            cfg.cfg_address <= '0;
            cfg.cfg_data_in <= '0;
        end else begin
            cfg.cfg_write <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state  <= ST_HEADER;
                        busy   <= 1'b1;
                        count  <= '0;
                        hdr_sr <= '0;
                        wdata  <= '0;
                    end
                end
                ST_HEADER: begin
                    if (cs_rise) begin
                        state     <= ST_ABORT;
                        frame_err <= 1'b1;
                    end else if (count == HDR_CNT) begin
                        // Address was latched last cycle, so cfg_data_out is now valid.
                        if (hdr_sr[HLEN-1] == RW_WRITE) begin
                            state <= ST_WDATA;
                        end else begin
                            state <= ST_RDATA;
                            rd_sr <= cfg.cfg_data_out;
                        end
                    end else if (bit_take) begin
                        hdr_sr <= hdr_next;
                        count  <= count_inc;
                        if (count_inc == HDR_CNT) begin
                            cfg.cfg_address <= hdr_next[ADDR_W-1:0];
                        end
                    end
                end
                ST_WDATA: begin
                    if (bit_take) begin
                        wdata <= wdata_next;
                        count <= count_inc;
                    end
                    // A bit arriving with the cs_n rise is counted before the decision.
                    if (cs_rise) begin
                        if (cnt_after == FRAME_CNT) begin
                            state           <= ST_COMMIT;
                            cfg.cfg_write   <= 1'b1;
                            cfg.cfg_data_in <= bit_take ? wdata_next : wdata;
                        end else begin
                            state     <= ST_ABORT;
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_RDATA: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        sdo   <= 1'b0;
                    end else if (sclk_fall) begin
                        sdo   <= rd_sr[DATA_W-1];
                        rd_sr <= {rd_sr[DATA_W-2:0], 1'b0};
                    end
                end
                ST_COMMIT, ST_ABORT: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cfg_serial_bridge.sv
// Directed-frame bench for cfg_serial_bridge with a frame-level scoreboard
// and a register-bank model behind the cfg port.
module tb_cfg_serial_bridge;
    import cfg_bridge_pkg::*;

    localparam int AW = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sclk = 1'b0;
    logic cs_n = 1'b1;
    logic sdi = 1'b0;
    logic sdo, busy, frame_err;

    cfg_serial_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cfg_serial_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo), .busy(busy), .frame_err(frame_err), .cfg(bus)
    );

    always #5 clk = ~clk;

    // Register bank seen by the DUT: combinational read, clocked write.
    logic [DW-1:0] bank [1<<AW];
    assign bus.cfg_data_out = bank[bus.cfg_address];
    always @(posedge clk) if (bus.cfg_write) bank[bus.cfg_address] <= bus.cfg_data_in;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level expectations derived from the frame bits alone.
    logic [AW+DW-1:0] exp_q[$];
    int               exp_err = 0;
    logic [DW-1:0]    mbank [1<<AW];
    int               wr_seen = 0;
    int               err_seen = 0;
    logic [AW-1:0]    last_addr = '0;
    logic [DW-1:0]    last_data = '0;
    logic [AW+DW-1:0] sb_e;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.cfg_write) begin
                wr_seen++;
                last_addr = bus.cfg_address;
                last_data = bus.cfg_data_in;
                check("wr_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    sb_e = exp_q.pop_front();
                    check("wr_addr", 32'(bus.cfg_address), 32'(sb_e[AW+DW-1:DW]));
                    check("wr_data", 32'(bus.cfg_data_in), 32'(sb_e[DW-1:0]));
                end
            end
            if (frame_err) begin
                err_seen++;
                check("err_pending", 32'(exp_err > 0), 1);
                if (exp_err > 0) exp_err--;
            end
            check("strobe_exclusive", 32'(bus.cfg_write & frame_err), 0);
            if (!busy) check("sdo_idle", 32'(sdo), 0);
        end
    end

    // bits is left-aligned: bits[31] is the first bit on the wire.
    task automatic model_frame(input logic [31:0] bits, input int nbits,
                               output logic rd_valid, output logic [DW-1:0] rd_exp);
        logic          rw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rw = bits[31];
        a  = bits[30:28];
        d  = bits[27:12];
        rd_valid = 1'b0;
        rd_exp   = '0;
        if (nbits < HDR_LEN) begin
            exp_err++;
        end else if (rw) begin
            if (nbits >= FRAME_LEN) begin
                exp_q.push_back({a, d});
                mbank[a] = d;
            end else begin
                exp_err++;
            end
        end else if (nbits >= FRAME_LEN) begin
            rd_valid = 1'b1;
            rd_exp   = mbank[a];
        end
    endtask

    task automatic end_wait(input bit measure);
        int lat;
        if (measure) begin
            lat = 99;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (bus.cfg_write || frame_err || !busy) begin
                    lat = c;
                    break;
                end
            end
            check("end_latency", 32'(lat), 4);
            repeat (2) @(negedge clk);
            check("sb_drained", 32'(exp_q.size() + exp_err), 0);
        end
    endtask

    task automatic run_frame(input logic [31:0] bits, input int nbits, input bit coincide,
                             input bit measure, output logic [DW-1:0] rd);
        logic          rv;
        logic [DW-1:0] re;
        model_frame(bits, nbits, rv, re);
        rd   = '0;
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdi = bits[31-i];
            repeat (4) @(negedge clk);
            if (i >= HDR_LEN && i < FRAME_LEN) rd = {rd[DW-2:0], sdo};
            sclk = 1'b1;
            if (coincide && i == nbits - 1) begin
                cs_n = 1'b1;
                end_wait(measure);
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
        end
        if (!coincide) begin
            repeat (4) @(negedge clk);
            cs_n = 1'b1;
            end_wait(measure);
        end
        sdi = 1'b0;
        if (rv) check("read_data", 32'(rd), 32'(re));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        logic [31:0]   wbits;
        int            w0, e0;

        repeat (3) @(negedge clk);
        check("reset_outputs", {sdo, bus.cfg_write, busy, frame_err,
                                9'(bus.cfg_address), bus.cfg_data_in}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Full write of FFFF to address 0.
        w0 = wr_seen;
        run_frame({1'b1, 3'b000, 16'hFFFF, 12'h0}, 20, 1'b0, 1'b1, rd);
        check("t1_write_count", 32'(wr_seen - w0), 1);
        check("t1_addr", 32'(last_addr), 0);
        check("t1_data", 32'(last_data), 32'hFFFF);

        // Write then read back address 5.
        run_frame({1'b1, 3'b101, 16'hA5C3, 12'h0}, 20, 1'b0, 1'b1, rd);
        run_frame({1'b0, 3'b101, 16'h0000, 12'h0}, 20, 1'b0, 1'b1, rd);
        check("t2_read_literal", 32'(rd), 32'hA5C3);

        // Truncated write aborts without a strobe.
        w0 = wr_seen;
        e0 = err_seen;
        run_frame({1'b1, 3'b110, 16'hBEEF, 12'h0}, 12, 1'b0, 1'b1, rd);
        check("t3_no_write", 32'(wr_seen - w0), 0);
        check("t3_err_count", 32'(err_seen - e0), 1);
        check("t3_busy", 32'(busy), 0);

        // Over-long frame: trailing bits ignored.
        w0 = wr_seen;
        run_frame({1'b1, 3'b010, 16'h1234, 4'hF, 8'h0}, 24, 1'b0, 1'b1, rd);
        check("t4_write_count", 32'(wr_seen - w0), 1);
        check("t4_addr", 32'(last_addr), 2);
        check("t4_data", 32'(last_data), 32'h1234);

        // cs_n rises together with the 20th sclk rise.
        run_frame({1'b1, 3'b111, 16'h8001, 12'h0}, 20, 1'b1, 1'b1, rd);
        check("t5_data", 32'(last_data), 32'h8001);

        // cs_n rises inside the header.
        e0 = err_seen;
        run_frame({1'b1, 3'b011, 16'h0, 12'h0}, 3, 1'b0, 1'b1, rd);
        check("t6_err_count", 32'(err_seen - e0), 1);

        // Short read raises no error.
        e0 = err_seen;
        run_frame({1'b0, 3'b101, 16'h0, 12'h0}, 10, 1'b0, 1'b1, rd);
        check("t7_err_count", 32'(err_seen - e0), 0);

        // Reset after 10 bits of a write to address 1.
        w0 = wr_seen;
        wbits = {1'b1, 3'b001, 16'h5555, 12'h0};
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sdi = wbits[31-i];
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        check("t8_busy_before_reset", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check("t8_reset_outputs", {sdo, bus.cfg_write, busy, frame_err,
                                   9'(bus.cfg_address), bus.cfg_data_in}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        sdi  = 1'b0;
        repeat (6) @(negedge clk);
        check("t8_idle_after_reset", 32'(busy), 0);
        check("t8_no_write", 32'(wr_seen - w0), 0);
        run_frame({1'b1, 3'b011, 16'h0F0F, 12'h0}, 20, 1'b0, 1'b1, rd);
        check("t8_addr", 32'(last_addr), 3);
        check("t8_data", 32'(last_data), 32'h0F0F);

        // Back-to-back writes with a 3-cycle cs_n high gap.
        w0 = wr_seen;
        run_frame({1'b1, 3'b100, 16'hC0DE, 12'h0}, 20, 1'b0, 1'b0, rd);
        repeat (3) @(negedge clk);
        run_frame({1'b1, 3'b110, 16'h7E57, 12'h0}, 20, 1'b0, 1'b1, rd);
        check("t9_write_count", 32'(wr_seen - w0), 2);
        check("t9_addr", 32'(last_addr), 6);
        check("t9_data", 32'(last_data), 32'h7E57);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
